// File: rtl/stream_join.sv
// Joins one B beat with one C beat into a registered {C,B} output beat, 2 cycles after a joint handshake.
// A branch's ready drops while its slot waits for the partner, or while a full pair is stalled behind d_ready.
module stream_join #(
  parameter int DATA_BW = 8,
  parameter int CNT_BW  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 b_valid,
  input  logic [DATA_BW-1:0]   b_data,
  output logic                 b_ready,
  input  logic                 c_valid,
  input  logic [DATA_BW-1:0]   c_data,
  output logic                 c_ready,
  output logic                 d_valid,
  output logic [2*DATA_BW-1:0] d_data,
  input  logic                 d_ready,
  output logic [CNT_BW-1:0]    join_cnt
);

  logic                 b_full_q, b_full_d;
  logic [DATA_BW-1:0]   b_buf_q, b_buf_d;
  logic                 c_full_q, c_full_d;
  logic [DATA_BW-1:0]   c_buf_q, c_buf_d;
  logic                 d_valid_q, d_valid_d;
  logic [2*DATA_BW-1:0] d_data_q, d_data_d;
  logic [CNT_BW-1:0]    join_cnt_q, join_cnt_d;

  logic out_free, join_fire, b_fire, c_fire, d_fire;

  assign out_free  = !d_valid_q || d_ready;
  assign join_fire = b_full_q && c_full_q && out_free;
  // A full slot can refill in the same cycle its contents move to the output.
  assign b_ready   = !b_full_q || join_fire;
  assign c_ready   = !c_full_q || join_fire;
  assign b_fire    = b_valid && b_ready;
  assign c_fire    = c_valid && c_ready;
  assign d_fire    = d_valid_q && d_ready;

  always_comb begin
    b_full_d = b_full_q;
    b_buf_d  = b_buf_q;
    if (b_fire) begin
      b_full_d = 1'b1;
      b_buf_d  = b_data;
    end else if (join_fire) begin
      b_full_d = 1'b0;
    end
  end

  always_comb begin
    c_full_d = c_full_q;
    c_buf_d  = c_buf_q;
    if (c_fire) begin
      c_full_d = 1'b1;
      c_buf_d  = c_data;
    end else if (join_fire) begin
      c_full_d = 1'b0;
    end
  end

  always_comb begin
    d_valid_d  = d_valid_q;
    d_data_d   = d_data_q;
    join_cnt_d = join_cnt_q;
    if (join_fire) begin
      d_valid_d = 1'b1;
      d_data_d  = {c_buf_q, b_buf_q};
    end else if (d_fire) begin
      d_valid_d = 1'b0;
    end
    if (d_fire) begin
      join_cnt_d = join_cnt_q + CNT_BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_full_q   <= 1'b0;
      b_buf_q    <= '0;
      c_full_q   <= 1'b0;
      c_buf_q    <= '0;
      d_valid_q  <= 1'b0;
      d_data_q   <= '0;
      join_cnt_q <= '0;
    end else begin
      b_full_q   <= b_full_d;
      b_buf_q    <= b_buf_d;
      c_full_q   <= c_full_d;
      c_buf_q    <= c_buf_d;
      d_valid_q  <= d_valid_d;
      d_data_q   <= d_data_d;
      join_cnt_q <= join_cnt_d;
    end
  end

  assign d_valid  = d_valid_q;
  assign d_data   = d_data_q;
  assign join_cnt = join_cnt_q;

endmodule

// File: tb/tb_stream_join.sv
// Scoreboard bench for stream_join: branch drivers feed queued beats, a monitor checks every output beat.
module tb_stream_join;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        b_valid, c_valid, d_ready;
  logic [7:0]  b_data, c_data;
  logic        b_ready, c_ready, d_valid;
  logic [15:0] d_data;
  logic [15:0] join_cnt;
  logic        b_ready4, c_ready4, d_valid4;
  logic [15:0] d_data4;
  logic [3:0]  join_cnt4;

  logic        b_en, c_en;
  logic [7:0]  bq[$];
  logic [7:0]  cq[$];
  logic [15:0] exp_q[$];
  int          total, bad, n_out;

  always #5 clk = ~clk;

  stream_join dut (
    .clk(clk), .rst_n(rst_n),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
    .d_valid(d_valid), .d_data(d_data), .d_ready(d_ready),
    .join_cnt(join_cnt)
  );

  stream_join #(.DATA_BW(8), .CNT_BW(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready4),
    .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready4),
    .d_valid(d_valid4), .d_data(d_data4), .d_ready(d_ready),
    .join_cnt(join_cnt4)
  );

  task automatic drv_b();
    forever begin
      bit f;
      @(negedge clk);
      f = rst_n && b_valid && b_ready;
      @(posedge clk);
      #1;
      if (f && bq.size() > 0) bq.delete(0);
      b_valid = b_en && (bq.size() > 0);
      if (bq.size() > 0) b_data = bq[0];
    end
  endtask

  task automatic drv_c();
    forever begin
      bit f;
      @(negedge clk);
      f = rst_n && c_valid && c_ready;
      @(posedge clk);
      #1;
      if (f && cq.size() > 0) cq.delete(0);
      c_valid = c_en && (cq.size() > 0);
      if (cq.size() > 0) c_data = cq[0];
    end
  endtask

  // Pops the scoreboard on every output handshake and checks stall stability.
  task automatic monitor();
    bit          stall_prev = 1'b0;
    logic [15:0] data_prev  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          total++;
          if (d_valid !== 1'b1 || d_data !== data_prev) begin
            bad++;
            $display("FAIL stall_hold: d_valid=%0b d_data=%h required d_valid=1 d_data=%h", d_valid, d_data, data_prev);
          end
        end
        if (d_valid && d_ready) begin
          total++;
          n_out++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL out_beat: got %h, required no beat", d_data);
          end else begin
            if (d_data !== exp_q[0]) begin
              bad++;
              $display("FAIL out_beat: got %h, required %h", d_data, exp_q[0]);
            end
            exp_q.delete(0);
          end
        end
        stall_prev = d_valid && !d_ready;
        data_prev  = d_data;
      end
    end
  endtask

  task automatic push_pair(input logic [7:0] b, input logic [7:0] c);
    bq.push_back(b);
    cq.push_back(c);
    exp_q.push_back({c, b});
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    bq.delete();
    cq.delete();
    exp_q.delete();
    b_en = 1'b1;
    c_en = 1'b1;
    d_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] want);
    @(negedge clk);
    total++;
    if (join_cnt !== want) begin
      bad++;
      $display("FAIL %s_cnt: join_cnt=%0d required %0d", name, join_cnt, want);
    end
  endtask

  task automatic test_reset();
    bit found = 1'b0;
    rst_n = 1'b0;
    #3;
    total++;
    if (b_ready !== 1'b1 || c_ready !== 1'b1 || d_valid !== 1'b0 || d_data !== 16'h0 || join_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_vals: br=%0b cr=%0b dv=%0b dd=%h cnt=%0d required 1 1 0 0000 0",
               b_ready, c_ready, d_valid, d_data, join_cnt);
    end
    apply_reset();
    @(negedge clk);
    total++;
    if (b_ready !== 1'b1 || c_ready !== 1'b1 || d_valid !== 1'b0 || join_cnt !== 16'h0) begin
      bad++;
      $display("FAIL reset_release: br=%0b cr=%0b dv=%0b cnt=%0d required 1 1 0 0", b_ready, c_ready, d_valid, join_cnt);
    end
    push_pair(8'h11, 8'h22);
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (b_valid && b_ready && c_valid && c_ready) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL first_handshake: no joint handshake seen, required one within 10 cycles");
    end
    @(negedge clk);
    total++;
    if (d_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_k1: d_valid=%0b required 0", d_valid);
    end
    @(negedge clk);
    total++;
    if (d_valid !== 1'b1 || d_data !== 16'h2211) begin
      bad++;
      $display("FAIL latency_k2: d_valid=%0b d_data=%h required 1 2211", d_valid, d_data);
    end
    check_cnt("reset", 16'd1);
  endtask

  task automatic test_skew();
    int base;
    apply_reset();
    c_en = 1'b0;
    base = n_out;
    bq.push_back(8'hA1);
    bq.push_back(8'hA2);
    cq.push_back(8'hC1);
    cq.push_back(8'hC2);
    exp_q.push_back(16'hC1A1);
    exp_q.push_back(16'hC2A2);
    repeat (6) @(negedge clk);
    total++;
    if (b_ready !== 1'b0 || b_valid !== 1'b1 || d_valid !== 1'b0) begin
      bad++;
      $display("FAIL skew_hold: b_ready=%0b b_valid=%0b d_valid=%0b required 0 1 0", b_ready, b_valid, d_valid);
    end
    @(posedge clk);
    #1;
    c_en = 1'b1;
    wait_drain("skew");
    total++;
    if (n_out - base !== 2) begin
      bad++;
      $display("FAIL skew_count: %0d outputs, required 2", n_out - base);
    end
    check_cnt("skew", 16'd2);
  endtask

  task automatic test_stream();
    bit found = 1'b0;
    int gaps = 0;
    apply_reset();
    for (int i = 0; i < 256; i++) push_pair(8'(i), 8'(255 - i));
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (d_valid) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL stream_start: d_valid=0 required 1 within 10 cycles");
    end
    for (int i = 1; i < 256; i++) begin
      @(negedge clk);
      if (!d_valid) gaps++;
    end
    total++;
    if (gaps !== 0) begin
      bad++;
      $display("FAIL stream_rate: %0d bubbles, required 0", gaps);
    end
    check_cnt("stream", 16'd256);
    wait_drain("stream");
  endtask

  task automatic test_backpressure();
    int base;
    apply_reset();
    @(posedge clk);
    #1;
    d_ready = 1'b0;
    base = n_out;
    for (int i = 0; i < 3; i++) push_pair(8'(8'h10 + i), 8'(8'h20 + i));
    repeat (6) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (d_valid !== 1'b1 || d_data !== 16'h2010 || b_ready !== 1'b0 || c_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_stall: dv=%0b dd=%h br=%0b cr=%0b required 1 2010 0 0", d_valid, d_data, b_ready, c_ready);
      end
    end
    @(posedge clk);
    #1;
    d_ready = 1'b1;
    #1;
    total++;
    if (b_ready !== 1'b1 || c_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: br=%0b cr=%0b required 1 1", b_ready, c_ready);
    end
    wait_drain("bp");
    total++;
    if (n_out - base !== 3) begin
      bad++;
      $display("FAIL bp_count: %0d outputs, required 3", n_out - base);
    end
    check_cnt("bp", 16'd3);
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 17; i++) push_pair(8'(i * 3), 8'(i * 5));
    wait_drain("wrap");
    check_cnt("wrap", 16'd17);
    total++;
    if (join_cnt4 !== 4'd1) begin
      bad++;
      $display("FAIL wrap_cnt4: join_cnt=%0d required 1", join_cnt4);
    end
  endtask

  task automatic test_mid_reset();
    int base;
    apply_reset();
    @(posedge clk);
    #1;
    d_ready = 1'b0;
    push_pair(8'h55, 8'h66);
    bq.push_back(8'h77);
    repeat (6) @(negedge clk);
    total++;
    if (d_valid !== 1'b1 || b_ready !== 1'b0 || c_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_setup: dv=%0b br=%0b cr=%0b required 1 0 1", d_valid, b_ready, c_ready);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bq.delete();
    cq.delete();
    exp_q.delete();
    #1;
    total++;
    if (d_valid !== 1'b0 || d_data !== 16'h0 || b_ready !== 1'b1 || c_ready !== 1'b1 || join_cnt !== 16'h0) begin
      bad++;
      $display("FAIL mid_async: dv=%0b dd=%h br=%0b cr=%0b cnt=%0d required 0 0000 1 1 0",
               d_valid, d_data, b_ready, c_ready, join_cnt);
    end
    repeat (2) @(posedge clk);
    #2;
    d_ready = 1'b1;
    rst_n = 1'b1;
    base = n_out;
    push_pair(8'h33, 8'h44);
    wait_drain("mid");
    total++;
    if (n_out - base !== 1) begin
      bad++;
      $display("FAIL mid_count: %0d outputs, required 1", n_out - base);
    end
    check_cnt("mid", 16'd1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    n_out = 0;
    rst_n = 1'b0;
    b_en = 1'b1;
    c_en = 1'b1;
    b_valid = 1'b0;
    c_valid = 1'b0;
    b_data = '0;
    c_data = '0;
    d_ready = 1'b1;
    fork
      drv_b();
      drv_c();
      monitor();
    join_none
    test_reset();
    test_skew();
    test_stream();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
